// File: rtl/tlb_assoc_param.sv
// Fully associative TLB with per-entry page type, ASID / global matching,
// fill-free-first then round-robin replacement, a registered lookup
// response and saturating hit/miss counters.
module tlb_assoc_param #(
    parameter int ENTRIES = 64,
    parameter int ASID_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lk_valid,
    input  logic [31:0]       i_lk_va,
    input  logic [ASID_W-1:0] i_lk_asid,
    output logic              o_rsp_valid,
    output logic              o_rsp_hit,
    output logic              o_rsp_asid_neq,
    output logic [31:0]       o_rsp_pa,
    output logic [3:0]        o_rsp_domain,
    output logic [1:0]        o_rsp_ap,
    output logic              o_rsp_apx,
    input  logic              i_wr,
    input  logic [1:0]        i_wr_type,
    input  logic [19:0]       i_wr_va,
    input  logic [19:0]       i_wr_pa,
    input  logic [ASID_W-1:0] i_wr_asid,
    input  logic              i_wr_global,
    input  logic [3:0]        i_wr_domain,
    input  logic [7:0]        i_wr_ap,
    input  logic              i_wr_apx,
    input  logic              i_inv_all,
    input  logic              i_inv_mva,
    input  logic              i_inv_asid,
    input  logic [19:0]       i_inv_va,
    input  logic [ASID_W-1:0] i_inv_asid_val,
    output logic              o_full,
    output logic [CNT_W-1:0]  o_hit_cnt,
    output logic [CNT_W-1:0]  o_miss_cnt
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Significant bits of VA[31:12] / PA[31:12] for each page type.
    function automatic logic [19:0] page_mask(input logic [1:0] t);
        case (t)
            2'd0:    page_mask = 20'hFF000;
            2'd1:    page_mask = 20'hFFF00;
            2'd2:    page_mask = 20'hFFFF0;
            default: page_mask = 20'hFFFFF;
        endcase
    endfunction

    // Sections use the top AP field; pages pick one of four subpage fields.
    function automatic logic [1:0] select_ap(input logic [1:0] t, input logic [31:0] va,
                                             input logic [7:0] ap);
        logic [1:0] sub;
        case (t)
            2'd2:    sub = va[15:14];
            2'd3:    sub = va[11:10];
            default: sub = 2'd3;
        endcase
        case (sub)
            2'd0:    select_ap = ap[1:0];
            2'd1:    select_ap = ap[3:2];
            2'd2:    select_ap = ap[5:4];
            default: select_ap = ap[7:6];
        endcase
    endfunction

    // Entry storage; only the valid bits need reset.
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         type_q   [ENTRIES];
    logic [19:0]        va_q     [ENTRIES];
    logic [19:0]        pa_q     [ENTRIES];
    logic [ASID_W-1:0]  asid_q   [ENTRIES];
    logic               global_q [ENTRIES];
    logic [3:0]         domain_q [ENTRIES];
    logic [7:0]         ap_q     [ENTRIES];
    logic               apx_q    [ENTRIES];
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    // Per-entry compare results.
    logic [ENTRIES-1:0] lk_tag_hit, lk_asid_ok, lk_hit_vec, inv_mva_hit, inv_asid_hit;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
        logic [19:0] mask;
        assign mask              = page_mask(type_q[gi]);
        assign lk_tag_hit[gi]    = valid_q[gi] && ((i_lk_va[31:12] & mask) == va_q[gi]);
        assign lk_asid_ok[gi]    = global_q[gi] || (asid_q[gi] == i_lk_asid);
        assign inv_mva_hit[gi]   = valid_q[gi] && ((i_inv_va & mask) == va_q[gi])
                                   && (global_q[gi] || (asid_q[gi] == i_inv_asid_val));
        assign inv_asid_hit[gi]  = valid_q[gi] && !global_q[gi] && (asid_q[gi] == i_inv_asid_val);
    end
    assign lk_hit_vec = lk_tag_hit & lk_asid_ok;

    logic             any_hit, any_free, inv_any, blocked, wr_en;
    logic [IDX_W-1:0] hit_idx, free_idx, wr_idx;

    assign any_hit  = |lk_hit_vec;
    assign any_free = ~&valid_q;
    assign inv_any  = i_inv_all | i_inv_mva | i_inv_asid;
    assign blocked  = inv_any | i_wr;
    assign wr_en    = i_wr & ~inv_any;
    assign wr_idx   = any_free ? free_idx : ptr_q;

    // Lowest-index priority encoders for the hit and the first free slot.
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (lk_hit_vec[i]) hit_idx = IDX_W'(i);
            if (!valid_q[i])   free_idx = IDX_W'(i);
        end
    end

    // Translation of the winning entry, merged with the untranslated VA bits.
    logic [19:0] sel_mask;
    logic [31:0] sel_pa;
    logic [1:0]  sel_ap;
    logic        rsp_hit_d, rsp_neq_d;

    always_comb begin
        sel_mask  = page_mask(type_q[hit_idx]);
        sel_pa    = {pa_q[hit_idx] | (i_lk_va[31:12] & ~sel_mask), i_lk_va[11:0]};
        sel_ap    = select_ap(type_q[hit_idx], i_lk_va, ap_q[hit_idx]);
        rsp_hit_d = i_lk_valid & ~blocked & any_hit;
        rsp_neq_d = i_lk_valid & ~blocked & ~any_hit & |(lk_tag_hit & ~lk_asid_ok);
    end

    // Valid-bit and fill-pointer next state; invalidates outrank the refill.
    always_comb begin
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (i_inv_all) begin
            valid_d = '0;
            ptr_d   = '0;
        end else if (i_inv_mva) begin
            valid_d = valid_q & ~inv_mva_hit;
        end else if (i_inv_asid) begin
            valid_d = valid_q & ~inv_asid_hit;
        end else if (i_wr) begin
            valid_d[wr_idx] = 1'b1;
            if (!any_free) ptr_d = ptr_q + 1'b1;
        end
    end

    // Valid bits, fill pointer and full flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            ptr_q   <= '0;
            o_full  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            o_full  <= &valid_d;
        end
    end

    // Refill data, stored with the unused low address bits already cleared.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_store
        always_ff @(posedge i_clk) begin
            if (wr_en && (wr_idx == IDX_W'(gi))) begin
                type_q[gi]   <= i_wr_type;
                va_q[gi]     <= i_wr_va & page_mask(i_wr_type);
                pa_q[gi]     <= i_wr_pa & page_mask(i_wr_type);
                asid_q[gi]   <= i_wr_asid;
                global_q[gi] <= i_wr_global;
                domain_q[gi] <= i_wr_domain;
                ap_q[gi]     <= i_wr_ap;
                apx_q[gi]    <= i_wr_apx;
            end
        end
    end

    // Registered lookup response; translation fields only change on a hit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid    <= 1'b0;
            o_rsp_hit      <= 1'b0;
            o_rsp_asid_neq <= 1'b0;
            o_rsp_pa       <= '0;
            o_rsp_domain   <= '0;
            o_rsp_ap       <= '0;
            o_rsp_apx      <= 1'b0;
        end else begin
            o_rsp_valid    <= i_lk_valid;
            o_rsp_hit      <= rsp_hit_d;
            o_rsp_asid_neq <= rsp_neq_d;
            if (rsp_hit_d) begin
                o_rsp_pa     <= sel_pa;
                o_rsp_domain <= domain_q[hit_idx];
                o_rsp_ap     <= sel_ap;
                o_rsp_apx    <= apx_q[hit_idx];
            end
        end
    end

    // Saturating statistics, updated together with the response they count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else if (i_lk_valid) begin
            if (rsp_hit_d) begin
                if (o_hit_cnt != '1) o_hit_cnt <= o_hit_cnt + 1'b1;
            end else begin
                if (o_miss_cnt != '1) o_miss_cnt <= o_miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tlb_assoc_param.sv
module tb_tlb_assoc_param;
    localparam int E   = 8;
    localparam int AW  = 8;
    localparam int CW  = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, lk_valid, wr, wr_global, wr_apx, inv_all, inv_mva, inv_asid;
    logic [31:0]   lk_va;
    logic [AW-1:0] lk_asid, wr_asid, inv_asid_val;
    logic [1:0]    wr_type;
    logic [19:0]   wr_va, wr_pa, inv_va;
    logic [3:0]    wr_domain;
    logic [7:0]    wr_ap;
    logic          rsp_valid, rsp_hit, rsp_neq, rsp_apx, full;
    logic [31:0]   rsp_pa;
    logic [3:0]    rsp_domain;
    logic [1:0]    rsp_ap;
    logic [CW-1:0] hit_cnt, miss_cnt;

    tlb_assoc_param #(.ENTRIES(E), .ASID_W(AW), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_lk_valid(lk_valid), .i_lk_va(lk_va), .i_lk_asid(lk_asid),
        .o_rsp_valid(rsp_valid), .o_rsp_hit(rsp_hit), .o_rsp_asid_neq(rsp_neq),
        .o_rsp_pa(rsp_pa), .o_rsp_domain(rsp_domain), .o_rsp_ap(rsp_ap), .o_rsp_apx(rsp_apx),
        .i_wr(wr), .i_wr_type(wr_type), .i_wr_va(wr_va), .i_wr_pa(wr_pa), .i_wr_asid(wr_asid),
        .i_wr_global(wr_global), .i_wr_domain(wr_domain), .i_wr_ap(wr_ap), .i_wr_apx(wr_apx),
        .i_inv_all(inv_all), .i_inv_mva(inv_mva), .i_inv_asid(inv_asid),
        .i_inv_va(inv_va), .i_inv_asid_val(inv_asid_val),
        .o_full(full), .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a list of translations with full byte addresses.
    bit            m_v    [E];
    int unsigned   m_type [E];
    logic [31:0]   m_va   [E];
    logic [31:0]   m_pa   [E];
    logic [AW-1:0] m_asid [E];
    bit            m_glob [E];
    logic [3:0]    m_dom  [E];
    logic [7:0]    m_ap   [E];
    bit            m_apx  [E];
    int            m_ptr;
    logic          e_valid, e_hit, e_neq, e_apx, e_full;
    logic [31:0]   e_pa;
    logic [3:0]    e_dom;
    logic [1:0]    e_ap;
    int            e_hc, e_mc;

    // Page size in address bits: 16MB, 1MB, 64KB, 4KB.
    function automatic int page_shift(int unsigned t);
        return 24 - 4 * int'(t);
    endfunction

    function automatic bit same_page(logic [31:0] a, logic [31:0] b, int unsigned t);
        return (a >> page_shift(t)) == (b >> page_shift(t));
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < E; i++) m_v[i] = 0;
        m_ptr = 0; e_hc = 0; e_mc = 0;
        e_valid = 0; e_hit = 0; e_neq = 0; e_apx = 0; e_full = 0;
        e_pa = 0; e_dom = 0; e_ap = 0;
    endtask

    task automatic model_step();
        bit blocked, neq, any_free;
        int hit_i, s, sub, idx;
        blocked = inv_all | inv_mva | inv_asid | wr;
        e_valid = lk_valid; e_hit = 0; e_neq = 0;
        if (lk_valid) begin
            hit_i = -1; neq = 0;
            if (!blocked) begin
                for (int i = 0; i < E; i++) begin
                    if (m_v[i] && same_page(lk_va, m_va[i], m_type[i])) begin
                        if (m_glob[i] || m_asid[i] == lk_asid) begin
                            if (hit_i < 0) hit_i = i;
                        end else neq = 1;
                    end
                end
            end
            if (hit_i >= 0) begin
                s = page_shift(m_type[hit_i]);
                e_hit = 1;
                e_pa  = ((m_pa[hit_i] >> s) << s) | (lk_va & ((32'h1 << s) - 32'h1));
                e_dom = m_dom[hit_i];
                e_apx = m_apx[hit_i];
                if (m_type[hit_i] < 2) sub = 3;
                else sub = int'((lk_va >> (s - 2)) & 32'h3);
                e_ap = 2'((m_ap[hit_i] >> (2 * sub)) & 8'h3);
                if (e_hc < CMAX) e_hc++;
            end else begin
                e_neq = neq;
                if (e_mc < CMAX) e_mc++;
            end
        end
        if (inv_all) begin
            for (int i = 0; i < E; i++) m_v[i] = 0;
            m_ptr = 0;
        end else if (inv_mva) begin
            for (int i = 0; i < E; i++)
                if (m_v[i] && same_page({inv_va, 12'h0}, m_va[i], m_type[i])
                    && (m_glob[i] || m_asid[i] == inv_asid_val)) m_v[i] = 0;
        end else if (inv_asid) begin
            for (int i = 0; i < E; i++)
                if (m_v[i] && !m_glob[i] && m_asid[i] == inv_asid_val) m_v[i] = 0;
        end else if (wr) begin
            any_free = 0; idx = 0;
            for (int i = E - 1; i >= 0; i--)
                if (!m_v[i]) begin any_free = 1; idx = i; end
            if (!any_free) begin idx = m_ptr; m_ptr = (m_ptr + 1) % E; end
            m_v[idx] = 1; m_type[idx] = wr_type; m_va[idx] = {wr_va, 12'h0};
            m_pa[idx] = {wr_pa, 12'h0}; m_asid[idx] = wr_asid; m_glob[idx] = wr_global;
            m_dom[idx] = wr_domain; m_ap[idx] = wr_ap; m_apx[idx] = wr_apx;
        end
        e_full = 1;
        for (int i = 0; i < E; i++) if (!m_v[i]) e_full = 0;
    endtask

    task automatic check_all();
        chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
        chk("rsp_hit", 32'(rsp_hit), 32'(e_hit));
        chk("rsp_asid_neq", 32'(rsp_neq), 32'(e_neq));
        chk("rsp_pa", rsp_pa, e_pa);
        chk("rsp_domain", 32'(rsp_domain), 32'(e_dom));
        chk("rsp_ap", 32'(rsp_ap), 32'(e_ap));
        chk("rsp_apx", 32'(rsp_apx), 32'(e_apx));
        chk("full", 32'(full), 32'(e_full));
        chk("hit_cnt", 32'(hit_cnt), 32'(e_hc));
        chk("miss_cnt", 32'(miss_cnt), 32'(e_mc));
    endtask

    // One clock: model the cycle, let the DUT take the edge, compare, clear strobes.
    task automatic cycle();
        if (rst) model_reset(); else model_step();
        @(posedge clk); #1;
        check_all();
        $display("t=%0t lk=%0b va=%h asid=%h wr=%0b inv=%0b%0b%0b -> v=%0b hit=%0b neq=%0b pa=%h ap=%0d full=%0b hc=%0d mc=%0d",
                 $time, lk_valid, lk_va, lk_asid, wr, inv_all, inv_mva, inv_asid,
                 rsp_valid, rsp_hit, rsp_neq, rsp_pa, rsp_ap, full, hit_cnt, miss_cnt);
        rst = 0; lk_valid = 0; wr = 0; inv_all = 0; inv_mva = 0; inv_asid = 0;
    endtask

    task automatic set_lk(logic [31:0] va, logic [AW-1:0] asid);
        lk_valid = 1; lk_va = va; lk_asid = asid;
    endtask

    task automatic set_wr(logic [1:0] t, logic [19:0] va, logic [19:0] pa, logic [AW-1:0] asid,
                          logic g, logic [3:0] dom, logic [7:0] ap, logic apx);
        wr = 1; wr_type = t; wr_va = va; wr_pa = pa; wr_asid = asid;
        wr_global = g; wr_domain = dom; wr_ap = ap; wr_apx = apx;
    endtask

    initial begin
        logic [19:0] pv;
        int r;
        rst = 1; lk_valid = 0; lk_va = 0; lk_asid = 0;
        wr = 0; wr_type = 0; wr_va = 0; wr_pa = 0; wr_asid = 0; wr_global = 0;
        wr_domain = 0; wr_ap = 0; wr_apx = 0;
        inv_all = 0; inv_mva = 0; inv_asid = 0; inv_va = 0; inv_asid_val = 0;

        // Reset
        cycle(); rst = 1; cycle();
        chk("reset_full", 32'(full), 32'h0);
        chk("reset_pa", rsp_pa, 32'h0);

        // Miss on empty TLB
        set_lk(32'h0040_1234, 8'd1); cycle();
        chk("empty_valid", 32'(rsp_valid), 32'h1);
        chk("empty_miss_cnt", 32'(miss_cnt), 32'h1);

        // Small page with subpage AP, then ASID mismatch
        set_wr(2'd3, 20'h00401, 20'h8A5C3, 8'd1, 1'b0, 4'd5, 8'hE4, 1'b1); cycle();
        set_lk(32'h0040_1C34, 8'd1); cycle();
        chk("small_hit", 32'(rsp_hit), 32'h1);
        chk("small_pa", rsp_pa, 32'h8A5C_3C34);
        chk("small_ap", 32'(rsp_ap), 32'h3);
        set_lk(32'h0040_1C34, 8'd2); cycle();
        chk("asid_neq", 32'(rsp_neq), 32'h1);
        chk("miss_holds_pa", rsp_pa, 32'h8A5C_3C34);

        // Global supersection
        set_wr(2'd0, 20'h12300, 20'h45000, 8'd9, 1'b1, 4'd2, 8'h9B, 1'b0); cycle();
        set_lk(32'h12AB_CDEF, 8'h5A); cycle();
        chk("super_pa", rsp_pa, 32'h45AB_CDEF);
        chk("super_ap", 32'(rsp_ap), 32'h2);

        // Invalidate by ASID keeps the global entry
        inv_asid = 1; inv_asid_val = 8'd1; cycle();
        set_lk(32'h0040_1C34, 8'd1); cycle();
        chk("inv_asid_gone", 32'(rsp_hit), 32'h0);
        set_lk(32'h12AB_CDEF, 8'd1); cycle();
        chk("inv_asid_global_kept", 32'(rsp_hit), 32'h1);
        inv_all = 1; cycle();
        set_lk(32'h12AB_CDEF, 8'd1); cycle();
        chk("inv_all_gone", 32'(rsp_hit), 32'h0);
        chk("inv_all_not_full", 32'(full), 32'h0);

        // Fill beyond capacity: round-robin replaces entries 0 and 1
        for (int k = 0; k < E + 2; k++) begin
            set_wr(2'd3, 20'h20000 + 20'(k), 20'h70000 + 20'(k), 8'd1, 1'b0, 4'd1, 8'h55, 1'b0);
            cycle();
            if (k == E - 2) chk("fill_not_full", 32'(full), 32'h0);
            if (k == E - 1) chk("fill_full", 32'(full), 32'h1);
        end
        set_lk(32'h2000_0010, 8'd1); cycle();
        chk("evicted_page0", 32'(rsp_hit), 32'h0);
        set_lk(32'h2000_2010, 8'd1); cycle();
        chk("kept_page2", rsp_pa, 32'h7000_2010);
        set_lk(32'h2000_8010, 8'd1); cycle();
        chk("new_page8", rsp_pa, 32'h7000_8010);

        // Lookup colliding with a write, then retried
        set_wr(2'd3, 20'h30000, 20'h11111, 8'd2, 1'b0, 4'd7, 8'hFF, 1'b1);
        set_lk(32'h3000_0ABC, 8'd2); cycle();
        chk("collide_valid", 32'(rsp_valid), 32'h1);
        chk("collide_hit", 32'(rsp_hit), 32'h0);
        set_lk(32'h3000_0ABC, 8'd2); cycle();
        chk("retry_pa", rsp_pa, 32'h1111_1ABC);

        // Randomised mix of refills, invalidates and lookups
        for (int n = 0; n < 500; n++) begin
            r  = $urandom_range(0, 99);
            pv = 20'h12000 | (20'($urandom_range(0, 3)) << 8) | (20'($urandom_range(0, 3)) << 4)
                 | 20'($urandom_range(0, 3));
            if (r < 30) begin
                set_wr(2'($urandom_range(0, 3)), pv, 20'($urandom), 8'($urandom_range(0, 3)),
                       ($urandom_range(0, 7) == 0), 4'($urandom), 8'($urandom), 1'($urandom));
            end else if (r < 34) begin
                inv_mva = 1; inv_va = pv; inv_asid_val = 8'($urandom_range(0, 3));
            end else if (r < 36) begin
                inv_asid = 1; inv_asid_val = 8'($urandom_range(0, 3));
            end else if (r < 37) begin
                inv_all = 1;
            end
            if ($urandom_range(0, 99) < 75) begin
                pv = 20'h12000 | (20'($urandom_range(0, 3)) << 8) | (20'($urandom_range(0, 3)) << 4)
                     | 20'($urandom_range(0, 3));
                set_lk({pv, 12'($urandom)}, 8'($urandom_range(0, 3)));
            end
            cycle();
        end

        // Counter saturation
        inv_all = 1; cycle();
        set_wr(2'd1, 20'h40000, 20'h50000, 8'd0, 1'b1, 4'd3, 8'h40, 1'b0); cycle();
        for (int n = 0; n < CMAX + 8; n++) begin
            set_lk(32'h4001_2345, 8'd3); cycle();
        end
        chk("hit_cnt_saturated", 32'(hit_cnt), 32'(CMAX));
        chk("section_pa", rsp_pa, 32'h5001_2345);
        chk("section_ap", 32'(rsp_ap), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tlb_assoc_param.md
Name: tlb_assoc_param

Overview:
Parametrised, fully associative translation lookaside buffer for the MMU. It is the successor to the fixed 256-entry TLB. It adds:
- configurable depth and ASID width;
- global (ASID-independent) entries;
- size-correct tag compare for all four page types;
- fill into free entries first, with round-robin replacement once full;
- a registered lookup response with hit, miss and ASID-mismatch status;
- hit/miss statistics counters.

It sits between the core's address path and the page-table walker: a miss triggers a walk, and the walker refills the TLB through the write port.

Parameters:
ENTRIES, 64, number of entries; must be a power of 2, minimum 2.
ASID_W, 8, ASID width in bits.
CNT_W, 16, width of the hit and miss statistics counters.

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, synchronous, active-high
i_lk_valid  input  1  lookup request
i_lk_va  input  32  lookup virtual address
i_lk_asid  input  ASID_W  current ASID
o_rsp_valid  output  1  lookup response valid, one cycle after the request
o_rsp_hit  output  1  translation found
o_rsp_asid_neq  output  1  tag matched but ASID differed on a non-global entry; no hit anywhere
o_rsp_pa  output  32  physical address
o_rsp_domain  output  4  domain
o_rsp_ap  output  2  selected AP
o_rsp_apx  output  1  APX
i_wr  input  1  refill strobe
i_wr_type  input  2  0 supersection, 1 section, 2 large page, 3 small page
i_wr_va  input  20  VA[31:12]
i_wr_pa  input  20  PA[31:12]
i_wr_asid  input  ASID_W  ASID of the entry
i_wr_global  input  1  entry matches any ASID
i_wr_domain  input  4  domain
i_wr_ap  input  8  AP[11:4]; four 2-bit subpage fields
i_wr_apx  input  1  APX
i_inv_all  input  1  invalidate every entry
i_inv_mva  input  1  invalidate by MVA and ASID
i_inv_asid  input  1  invalidate all non-global entries with the given ASID
i_inv_va  input  20  MVA[31:12]
i_inv_asid_val  input  ASID_W  ASID for the MVA and ASID-based invalidations
o_full  output  1  all entries valid
o_hit_cnt  output  CNT_W  hit count
o_miss_cnt  output  CNT_W  miss count

Behaviour:
- Reset: all valid bits cleared, fill pointer 0, counters 0, and every output 0.
- Command priority per cycle: reset > invalidate (all > mva > asid) > write > lookup.
  - A lookup issued in the same cycle as a higher-priority command still responds: o_rsp_valid=1, o_rsp_hit=0, o_rsp_asid_neq=0, counted as a miss. The core must retry.
- Tag compare by stored type:
  - type 0 compares VA[31:24];
  - type 1 compares VA[31:20];
  - types 2 and 3 compare VA[31:16] and VA[31:12] respectively.
  - The write path zeroes the unused low VA/PA bits before storing.
- ASID match: entry global, or stored ASID == i_lk_asid.
- Hit = valid && tag match && ASID match.
- Multiple hits: the lowest index wins. Duplicates are software's responsibility, but the output must stay deterministic.
- PA composition:
  - type 0: {pa[31:24], va[23:0]}
  - type 1: {pa[31:20], va[19:0]}
  - type 2: {pa[31:16], va[15:0]}
  - type 3: {pa[31:12], va[11:0]}
- AP selection:
  - types 0 and 1 use ap[11:10];
  - type 2 selects a subpage by va[15:14];
  - type 3 selects a subpage by va[11:10];
  - in both subpage cases, 0→ap[5:4], 1→[7:6], 2→[9:8], 3→[11:10].
- Lookup latency: exactly 1 cycle. The response fields are registered.
  - o_rsp_valid is a 1-cycle pulse per request; back-to-back lookups are allowed every cycle.
  - On a miss, o_rsp_pa, o_rsp_domain, o_rsp_ap and o_rsp_apx hold their previous values.
- Write (refill):
  - Target is the lowest-index invalid entry if one exists; otherwise the entry at the fill pointer, which then increments modulo ENTRIES.
  - The pointer does not move when a free entry is used.
  - Written data is visible to a lookup issued the next cycle.
- Invalidate MVA: clears entries where the tag matches i_inv_va under the stored type's compare width AND (entry global OR ASID equal).
- Invalidate ASID: clears entries that are non-global with ASID equal to i_inv_asid_val.
- Invalidate all: clears every valid bit; the fill pointer resets to 0.
- o_full is registered and equals the AND of all valid bits after the cycle's update.
- Counters: each increments on its own response pulse and saturates at all-ones (no wrap).

Test Plan:
- Reset, then lookup va=0x0040_1234 asid=1 → next cycle rsp_valid=1, hit=0, miss_cnt=1, all other outputs 0.
- Write type 3, va 0x00401, pa 0x8A5C3, asid=1, ap=0xE4; lookup 0x0040_1C34 asid=1 → hit, pa=0x8A5C_3C34, ap=3 (va[11:10]=3); same address with asid=2 → hit=0, asid_neq=1.
- Write type 0 global, va 0x12300, pa 0x45000; lookup 0x12AB_CDEF with any asid → pa=0x45AB_CDEF, ap=ap[11:10].
- Fill ENTRIES+2 distinct small pages → o_full=1 after ENTRIES writes; the two extra writes replace entries 0 and 1; the original page-0 va now misses.
- Invalidate by ASID=1 with a global and a non-global entry present → only the non-global entry misses afterwards; inv_all → both miss, o_full=0.
- Lookup and write in the same cycle → rsp_valid=1, hit=0; repeat the lookup next cycle → hit with the new data.
